monolith_bricks_seq: RTL and testbench

Area-reduced, sequential implementation of the Monolith Bricks layer over the Mersenne-31 field (p = 2^31 − 1). It time-shares a single squaring multiplier and a single modular adder across all lanes of one permutation state. A lane scheduler issues one lane per cycle and drains the pipeline. Results are identical to the fully parallel Bricks layer; the block sits in the Monolith permutation datapath in place of the parallel layer when area matters more than throughput.

---
 rtl/monolith_bricks_seq.sv | 191 +++++++++++++++++++
 tb/tb_monolith_bricks_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monolith_bricks_seq.sv
// monolith_bricks_seq
// -------------------
// Sequential Monolith Bricks layer over GF(2^31 - 1):
//     out[0] = in[0]
//     out[i] = (in[i] + in[i-1]^2) mod p,   i = 1 .. STATE_SIZE-1
// The i-1 term is always the original input word.
// One squaring path and one modular adder are shared by all lanes.
// A scheduler issues one lane per cycle, from lane STATE_SIZE-1 down to lane 1,
// and then waits for the pipeline to drain.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   state_in is presented
//   in_ready   block is idle and accepts a state (registered)
//   state_in   input state, [0:STATE_SIZE-1] x WORD_WIDTH
//   out_valid  state_out holds a completed result (decoded from FSM state)
//   out_ready  consumer accepts the result
//   state_out  result state, [0:STATE_SIZE-1] x WORD_WIDTH
//   busy       high in every FSM state except IDLE
module monolith_bricks_seq #(
    parameter int WORD_WIDTH = 31,
    parameter int STATE_SIZE = 16,
    parameter int MUL_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] state_in  [0:STATE_SIZE-1],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] state_out [0:STATE_SIZE-1],
    output logic                  busy
);

    localparam int W      = WORD_WIDTH;
    localparam int LANE_W = $clog2(STATE_SIZE);
    // Up to MUL_LAT + 1 lanes can be in flight at once.
    localparam int PEND_W = $clog2(MUL_LAT + 3) + 1;

    localparam logic [W-1:0] P_MOD = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Mersenne fold: 2^W == 1 (mod p), so hi*2^W + lo == hi + lo.
    // For a square of a canonical value hi + lo < 2p, so one subtract suffices.
    function automatic logic [W-1:0] fold_sq(input logic [2*W-1:0] s);
        logic [W:0] sum;
        sum = {1'b0, s[2*W-1:W]} + {1'b0, s[W-1:0]};
        if (sum >= {1'b0, P_MOD}) begin
            sum = sum - {1'b0, P_MOD};
        end
        return sum[W-1:0];
    endfunction

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, P_MOD}) begin
            sum = sum - {1'b0, P_MOD};
        end
        return sum[W-1:0];
    endfunction

    logic [1:0]        state_reg, state_next;
    logic [LANE_W-1:0] cnt_reg;
    logic [PEND_W-1:0] pend_reg, pend_next;
    logic              in_ready_reg;
    logic [W-1:0]      st_reg   [0:STATE_SIZE-1];
    logic [W-1:0]      cap_word [0:STATE_SIZE-1];

    logic              accept;
    logic              issue;
    logic [W-1:0]      op_sq;
    logic [W-1:0]      op_carry;

    logic [2*W-1:0]    mul_data_reg  [0:MUL_LAT-1];
    logic [W-1:0]      mul_carry_reg [0:MUL_LAT-1];
    logic [LANE_W-1:0] mul_lane_reg  [0:MUL_LAT-1];
    logic              mul_vld_reg   [0:MUL_LAT-1];

    logic [W-1:0]      add_data_reg;
    logic [LANE_W-1:0] add_lane_reg;
    logic              add_vld_reg;

    assign accept = (state_reg == S_IDLE) && in_valid && in_ready_reg;
    assign issue  = (state_reg == S_ISSUE);

    // Descending issue order: st[cnt-1] has not been written back yet when it
    // is read here, so the original value is used without a shadow copy.
    assign op_sq    = st_reg[cnt_reg - LANE_W'(1)];
    assign op_carry = st_reg[cnt_reg];

    // The only non-canonical W-bit value is p itself, which maps to 0.
    generate
        for (genvar gi = 0; gi < STATE_SIZE; gi++) begin : g_lane
            assign cap_word[gi]  = (state_in[gi] == P_MOD) ? '0 : state_in[gi];
            assign state_out[gi] = st_reg[gi];
        end
    endgenerate

    // ---------------------------------------------------------------- control
    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg + PEND_W'(issue) - PEND_W'(add_vld_reg);
        case (state_reg)
            S_IDLE:  if (accept)                    state_next = S_ISSUE;
            S_ISSUE: if (cnt_reg == LANE_W'(1))     state_next = S_DRAIN;
            // Leave on the edge that performs the last writeback so DONE
            // already sees the complete result.
            S_DRAIN: if (pend_next == '0)           state_next = S_DONE;
            S_DONE:  if (out_ready)                 state_next = S_IDLE;
            default:                                state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            pend_reg     <= '0;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pend_reg     <= pend_next;
            in_ready_reg <= (state_next == S_IDLE);
            if (accept) begin
                cnt_reg <= LANE_W'(STATE_SIZE - 1);
            end else if (issue) begin
                cnt_reg <= cnt_reg - LANE_W'(1);
            end
        end
    end

    // --------------------------------------------------------- pipeline valids
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_vld_reg[i] <= 1'b0;
            end
            add_vld_reg <= 1'b0;
        end else begin
            mul_vld_reg[0] <= issue;
            for (int i = 1; i < MUL_LAT; i++) begin
                mul_vld_reg[i] <= mul_vld_reg[i-1];
            end
            add_vld_reg <= mul_vld_reg[MUL_LAT-1];
        end
    end

    // ------------------------------------------------------------- datapath
    // Stage 0 registers the full square; further stages delay it so the fold
    // can be retimed across them. The fold sits at the adder input.
    always_ff @(posedge clk) begin
        mul_data_reg[0]  <= {{W{1'b0}}, op_sq} * {{W{1'b0}}, op_sq};
        mul_carry_reg[0] <= op_carry;
        mul_lane_reg[0]  <= cnt_reg;
        for (int i = 1; i < MUL_LAT; i++) begin
            mul_data_reg[i]  <= mul_data_reg[i-1];
            mul_carry_reg[i] <= mul_carry_reg[i-1];
            mul_lane_reg[i]  <= mul_lane_reg[i-1];
        end
        add_data_reg <= add_mod(mul_carry_reg[MUL_LAT-1], fold_sq(mul_data_reg[MUL_LAT-1]));
        add_lane_reg <= mul_lane_reg[MUL_LAT-1];
    end

    // State bank: capture and writeback never coincide (writebacks only occur
    // while busy, capture only in IDLE).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STATE_SIZE; i++) begin
                st_reg[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < STATE_SIZE; i++) begin
                st_reg[i] <= cap_word[i];
            end
        end else if (add_vld_reg) begin
            st_reg[add_lane_reg] <= add_data_reg;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg == S_DONE);
    assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_monolith_bricks_seq.sv
module tb_monolith_bricks_seq;

    localparam int N  = 16;
    localparam int NS = 2;
    localparam logic [30:0] P = 31'h7fffffff;

    typedef logic [30:0] word_t;
    typedef word_t vec_t  [0:N-1];
    typedef word_t vecs_t [0:NS-1];

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    logic  in_valid, in_ready, out_valid, out_ready, busy;
    word_t state_in  [0:N-1];
    word_t state_out [0:N-1];
    logic  s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    word_t s_state_in  [0:NS-1];
    word_t s_state_out [0:NS-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    monolith_bricks_seq #(.WORD_WIDTH(31), .STATE_SIZE(N), .MUL_LAT(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
        .state_out(state_out), .busy(busy)
    );

    monolith_bricks_seq #(.WORD_WIDTH(31), .STATE_SIZE(NS), .MUL_LAT(1)) dut_small (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .state_in(s_state_in), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .state_out(s_state_out), .busy(s_busy)
    );

    // ------------------------------------------------------------ reference
    function automatic word_t canon(input word_t v);
        return (v == P) ? word_t'(0) : v;
    endfunction

    function automatic word_t ref_lane(input word_t cur, input word_t prev);
        longint c, q;
        c = longint'(canon(cur));
        q = longint'(canon(prev));
        return word_t'((c + q * q) % longint'(P));
    endfunction

    function automatic vec_t model16(input vec_t x);
        vec_t y;
        y[0] = canon(x[0]);
        for (int i = 1; i < N; i++) y[i] = ref_lane(x[i], x[i-1]);
        return y;
    endfunction

    function automatic vecs_t model2(input vecs_t x);
        vecs_t y;
        y[0] = canon(x[0]);
        y[1] = ref_lane(x[1], x[0]);
        return y;
    endfunction

    function automatic word_t rand_word();
        if ($urandom_range(0, 9) == 0) return P;
        return word_t'($urandom % 32'h7fffffff);
    endfunction

    // ------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents x, returns edges from accept to out_valid (-1 on timeout).
    task automatic run16(input vec_t x, output int lat, output vec_t y);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        state_in  = x;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) state_in[i] = word_t'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        lat = out_valid ? n : -1;
        y = state_out;
        $display("txn N=16 lat=%0d in0=%0d in1=%0d out1=%0d out15=%0d", lat, x[0], x[1], y[1], y[15]);
    endtask

    task automatic run2(input vecs_t x, output int lat, output vecs_t y);
        int n;
        n = 0;
        while (!s_in_ready && n < 50) begin tick(); n++; end
        s_state_in  = x;
        s_in_valid  = 1'b1;
        s_out_ready = 1'b0;
        tick();
        s_in_valid = 1'b0;
        for (int i = 0; i < NS; i++) s_state_in[i] = word_t'($urandom);
        n = 0;
        while (!s_out_valid && n < 100) begin tick(); n++; end
        lat = s_out_valid ? n : -1;
        y = s_state_out;
        $display("txn N=2 lat=%0d in0=%0d in1=%0d out0=%0d out1=%0d", lat, x[0], x[1], y[0], y[1]);
    endtask

    task automatic release16();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL reset_small_in_ready: got %b expected 0", s_in_ready); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (state_out[i] !== 31'd0) begin errors++; $display("FAIL reset_state_out lane %0d: got %0d expected 0", i, state_out[i]); end
        end
        reset = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_small_in_ready: got %b expected 1", s_in_ready); end
    endtask

    task automatic test_identity();
        vec_t x, y, e;
        int lat;
        for (int i = 0; i < N; i++) x[i] = word_t'(i);
        e = model16(x);
        run16(x, lat, y);
        checks++; if (lat !== 18) begin errors++; $display("FAIL ident_latency: got %0d expected 18", lat); end
        checks++; if (y[0] !== 31'd0) begin errors++; $display("FAIL ident_out0: got %0d expected 0", y[0]); end
        checks++; if (y[1] !== 31'd1) begin errors++; $display("FAIL ident_out1: got %0d expected 1", y[1]); end
        checks++; if (y[2] !== 31'd3) begin errors++; $display("FAIL ident_out2: got %0d expected 3", y[2]); end
        checks++; if (y[15] !== 31'd211) begin errors++; $display("FAIL ident_out15: got %0d expected 211", y[15]); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (y[i] !== e[i]) begin errors++; $display("FAIL ident lane %0d: got %0d expected %0d", i, y[i], e[i]); end
        end
        release16();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ident_release_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ident_release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_wrap();
        word_t in0_tab [0:3];
        word_t in1_tab [0:3];
        word_t exp_tab [0:3];
        vec_t x, y, e;
        int lat;
        in0_tab = '{P - 31'd1, 31'd1,     31'h40000000, P - 31'd1};
        in1_tab = '{31'd0,     P - 31'd1, 31'd0,        P - 31'd1};
        exp_tab = '{31'd1,     31'd0,     31'd536870912, 31'd0};
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++) x[i] = (c == 3) ? P - 31'd1 : rand_word();
            x[0] = in0_tab[c];
            x[1] = in1_tab[c];
            e = model16(x);
            run16(x, lat, y);
            checks++; if (lat !== 18) begin errors++; $display("FAIL wrap%0d_latency: got %0d expected 18", c, lat); end
            checks++; if (y[1] !== exp_tab[c]) begin errors++; $display("FAIL wrap%0d_out1: got %0d expected %0d", c, y[1], exp_tab[c]); end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (y[i] !== e[i]) begin errors++; $display("FAIL wrap%0d lane %0d: got %0d expected %0d", c, i, y[i], e[i]); end
            end
            release16();
        end
    endtask

    task automatic test_random();
        vec_t x, y, e;
        int lat;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) x[i] = rand_word();
            if (t == 0) x[4] = P;
            e = model16(x);
            run16(x, lat, y);
            checks++; if (lat !== 18) begin errors++; $display("FAIL random%0d_latency: got %0d expected 18", t, lat); end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (y[i] !== e[i]) begin errors++; $display("FAIL random%0d lane %0d: got %0d expected %0d", t, i, y[i], e[i]); end
            end
            release16();
        end
    endtask

    task automatic test_backpressure();
        vec_t x, y, e;
        int lat, bad;
        for (int i = 0; i < N; i++) x[i] = rand_word();
        e = model16(x);
        run16(x, lat, y);
        checks++; if (lat !== 18) begin errors++; $display("FAIL bp_latency: got %0d expected 18", lat); end
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            for (int i = 0; i < N; i++) state_in[i] = rand_word();
            tick();
            bad = 0;
            for (int i = 0; i < N; i++) if (state_out[i] !== e[i]) bad++;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cycle %0d: got %b expected 1", k, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", k, in_ready); end
            checks++; if (bad !== 0) begin errors++; $display("FAIL bp_state_out cycle %0d: got %0d bad lanes expected 0 (lane1 %0d vs %0d)", k, bad, state_out[1], e[1]); end
        end
        in_valid = 1'b0;
        release16();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        vec_t a, b, ea, eb, r0, r1;
        int acc_t [0:1];
        int hs_t  [0:1];
        int acc_cnt, hs_cnt;
        for (int i = 0; i < N; i++) begin a[i] = rand_word(); b[i] = rand_word(); end
        ea = model16(a);
        eb = model16(b);
        acc_cnt = 0; hs_cnt = 0;
        acc_t = '{-100, -100};
        hs_t  = '{-100, -100};
        state_in  = a;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 80 && hs_cnt < 2; t++) begin
            if (in_valid && in_ready) begin acc_t[acc_cnt] = t; acc_cnt++; end
            if (out_valid && out_ready) begin
                if (hs_cnt == 0) r0 = state_out; else r1 = state_out;
                hs_t[hs_cnt] = t;
                hs_cnt++;
            end
            tick();
            if (acc_cnt == 1) state_in = b;
            if (acc_cnt == 2) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        $display("txn b2b accepts=%0d,%0d handshakes=%0d,%0d", acc_t[0], acc_t[1], hs_t[0], hs_t[1]);
        checks++; if (hs_cnt !== 2) begin errors++; $display("FAIL b2b_handshakes: got %0d expected 2", hs_cnt); end
        checks++; if (hs_t[0] - acc_t[0] !== 19) begin errors++; $display("FAIL b2b_first_handshake: got %0d expected 19", hs_t[0] - acc_t[0]); end
        checks++; if (acc_t[1] - hs_t[0] !== 1) begin errors++; $display("FAIL b2b_reaccept_gap: got %0d expected 1", acc_t[1] - hs_t[0]); end
        checks++; if (acc_t[1] - acc_t[0] !== 20) begin errors++; $display("FAIL b2b_period: got %0d expected 20", acc_t[1] - acc_t[0]); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (r0[i] !== ea[i]) begin errors++; $display("FAIL b2b_first lane %0d: got %0d expected %0d", i, r0[i], ea[i]); end
            checks++;
            if (r1[i] !== eb[i]) begin errors++; $display("FAIL b2b_second lane %0d: got %0d expected %0d", i, r1[i], eb[i]); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        vec_t x, z, y;
        int lat, seen_valid, seen_nz;
        for (int i = 0; i < N; i++) begin x[i] = rand_word(); z[i] = 31'd0; end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_pre_in_ready: got %b expected 1", in_ready); end
        state_in = x;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b expected 1", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_busy_in_ready: got %b expected 0", in_ready); end
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("txn reset mid-operation applied");
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_after: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready_in_reset: got %b expected 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready_next: got %b expected 1", in_ready); end
        seen_valid = 0; seen_nz = 0;
        for (int k = 0; k < 30; k++) begin
            if (out_valid) seen_valid++;
            for (int i = 0; i < N; i++) if (state_out[i] !== 31'd0) seen_nz++;
            tick();
        end
        checks++; if (seen_valid !== 0) begin errors++; $display("FAIL rmid_late_out_valid: got %0d cycles expected 0", seen_valid); end
        checks++; if (seen_nz !== 0) begin errors++; $display("FAIL rmid_late_writeback: got %0d nonzero samples expected 0", seen_nz); end
        run16(z, lat, y);
        checks++; if (lat !== 18) begin errors++; $display("FAIL rmid_zero_latency: got %0d expected 18", lat); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (y[i] !== 31'd0) begin errors++; $display("FAIL rmid_zero lane %0d: got %0d expected 0", i, y[i]); end
        end
        release16();
    endtask

    task automatic test_param_sweep();
        vecs_t x, y, e;
        int lat;
        for (int t = 0; t < 8; t++) begin
            x[0] = rand_word();
            x[1] = rand_word();
            if (t == 0) begin x[0] = P - 31'd1; x[1] = 31'd0; end
            e = model2(x);
            run2(x, lat, y);
            checks++; if (lat !== 3) begin errors++; $display("FAIL sweep%0d_latency: got %0d expected 3", t, lat); end
            for (int i = 0; i < NS; i++) begin
                checks++;
                if (y[i] !== e[i]) begin errors++; $display("FAIL sweep%0d lane %0d: got %0d expected %0d", t, i, y[i], e[i]); end
            end
            s_out_ready = 1'b1;
            tick();
            s_out_ready = 1'b0;
            checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL sweep%0d_release: got %b expected 0", t, s_out_valid); end
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        for (int i = 0; i < N; i++) state_in[i] = 31'd0;
        for (int i = 0; i < NS; i++) s_state_in[i] = 31'd0;
        test_reset();
        test_identity();
        test_wrap();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
